// File: rtl/morra_cinese_param.sv
// Parametrised rock-paper-scissors match engine: scores one round per clock, ends on round limit or early-win margin.
// Define MORRA_BLOCK_RULE_EN to forbid the previous round's winner from repeating its winning move.
module morra_cinese_param #(
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned BASE_MANCHE = 4,
    parameter int unsigned MIN_MANCHE  = 4,
    parameter int unsigned WIN_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            primo,
    input  logic [1:0]            secondo,
    input  logic                  inizia,
    output logic [1:0]            manche,
    output logic [1:0]            partita,
    output logic signed [CNT_W:0] vantaggio,
    output logic [CNT_W-1:0]      num_manche,
    output logic                  busy
);
    localparam int unsigned VW = CNT_W + 1;

    localparam logic [1:0] SASSO   = 2'b01;
    localparam logic [1:0] CARTA   = 2'b10;
    localparam logic [1:0] FORBICE = 2'b11;

    localparam logic [1:0] R_NONE    = 2'b00;
    localparam logic [1:0] R_PRIMO   = 2'b01;
    localparam logic [1:0] R_SECONDO = 2'b10;
    localparam logic [1:0] R_TIE     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      max_r;
`ifdef MORRA_BLOCK_RULE_EN
    logic [1:0]            blk_mv;
    logic                  blk_sec;
`endif

    logic [1:0]            res_c;
    logic                  valid_c;
    logic [CNT_W-1:0]      num_nx_c;
    logic signed [CNT_W:0] van_nx_c;
    logic [CNT_W:0]        abs_c;
    logic                  end_c;
    logic [1:0]            fin_c;

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == SASSO) && (b == FORBICE)) ||
               ((a == FORBICE) && (b == CARTA)) ||
               ((a == CARTA) && (b == SASSO));
    endfunction

    // Round evaluation on the current inputs, end test on the would-be updated counters
    always_comb begin
        res_c = R_TIE;
        if (beats(primo, secondo)) begin
            res_c = R_PRIMO;
        end else if (beats(secondo, primo)) begin
            res_c = R_SECONDO;
        end

        valid_c = (primo != 2'b00) && (secondo != 2'b00);
`ifdef MORRA_BLOCK_RULE_EN
        if ((blk_mv != 2'b00) &&
            ((!blk_sec && (primo == blk_mv)) || (blk_sec && (secondo == blk_mv)))) begin
            valid_c = 1'b0;
        end
`endif

        num_nx_c = num_manche + CNT_W'(1);
        case (res_c)
            R_PRIMO:   van_nx_c = vantaggio + $signed(VW'(1));
            R_SECONDO: van_nx_c = vantaggio - $signed(VW'(1));
            default:   van_nx_c = vantaggio;
        endcase

        abs_c = van_nx_c[CNT_W] ? VW'(-van_nx_c) : VW'(van_nx_c);
        end_c = (num_nx_c == max_r) ||
                ((num_nx_c >= CNT_W'(MIN_MANCHE)) && (abs_c >= VW'(WIN_MARGIN)));

        if (van_nx_c[CNT_W]) begin
            fin_c = R_SECONDO;
        end else if (van_nx_c == '0) begin
            fin_c = R_TIE;
        end else begin
            fin_c = R_PRIMO;
        end
    end

    // Match FSM with registered outputs; inizia overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            max_r      <= '0;
            manche     <= R_NONE;
            partita    <= R_NONE;
            vantaggio  <= '0;
            num_manche <= '0;
            busy       <= 1'b0;
`ifdef MORRA_BLOCK_RULE_EN
            blk_mv     <= 2'b00;
            blk_sec    <= 1'b0;
`endif
        end else if (inizia) begin
            state      <= PLAY;
            max_r      <= CNT_W'({primo, secondo}) + CNT_W'(BASE_MANCHE);
            manche     <= R_NONE;
            partita    <= R_NONE;
            vantaggio  <= '0;
            num_manche <= '0;
            busy       <= 1'b1;
`ifdef MORRA_BLOCK_RULE_EN
            blk_mv     <= 2'b00;
            blk_sec    <= 1'b0;
`endif
        end else begin
            case (state)
                PLAY: begin
                    if (valid_c) begin
                        manche     <= res_c;
                        num_manche <= num_nx_c;
                        vantaggio  <= van_nx_c;
`ifdef MORRA_BLOCK_RULE_EN
                        if (res_c == R_TIE) begin
                            blk_mv <= 2'b00;
                        end else begin
                            blk_mv  <= (res_c == R_PRIMO) ? primo : secondo;
                            blk_sec <= (res_c == R_SECONDO);
                        end
`endif
                        if (end_c) begin
                            partita <= fin_c;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end
                    end else begin
                        manche <= R_NONE;
                    end
                end
                default: begin
                    manche <= R_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_morra_cinese_param.sv
// Self-checking bench for morra_cinese_param: directed test-plan steps plus random play against a rule-level model.
// Honours MORRA_BLOCK_RULE_EN the same way as the design.
module tb_morra_cinese_param;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned BASE_MANCHE = 4;
    localparam int unsigned MIN_MANCHE  = 4;
    localparam int unsigned WIN_MARGIN  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            primo;
    logic [1:0]            secondo;
    logic                  inizia;
    logic [1:0]            manche;
    logic [1:0]            partita;
    logic signed [CNT_W:0] vantaggio;
    logic [CNT_W-1:0]      num_manche;
    logic                  busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: moves 1..3, winner from (p - s) mod 3
    int m_state;      // 0 idle, 1 playing, 2 finished
    int m_max, m_num, m_adv;
    int m_lw, m_lm;   // last winner (0 none, 1 primo, 2 secondo) and its move
    int e_manche, e_partita;

    morra_cinese_param #(
        .CNT_W(CNT_W), .BASE_MANCHE(BASE_MANCHE), .MIN_MANCHE(MIN_MANCHE), .WIN_MARGIN(WIN_MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .primo(primo), .secondo(secondo), .inizia(inizia),
        .manche(manche), .partita(partita), .vantaggio(vantaggio),
        .num_manche(num_manche), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_max = 0; m_num = 0; m_adv = 0;
        m_lw = 0; m_lm = 0; e_manche = 0; e_partita = 0;
    endtask

    task automatic model_step(input int p, input int s, input bit ini);
        bit ok;
        int d, a;
        if (ini) begin
            m_max = p * 4 + s + int'(BASE_MANCHE);
            m_num = 0; m_adv = 0; m_lw = 0; m_lm = 0;
            e_manche = 0; e_partita = 0; m_state = 1;
        end else if (m_state != 1) begin
            e_manche = 0;
        end else begin
            ok = (p != 0) && (s != 0);
`ifdef MORRA_BLOCK_RULE_EN
            if ((m_lw == 1 && p == m_lm) || (m_lw == 2 && s == m_lm)) ok = 1'b0;
`endif
            if (!ok) begin
                e_manche = 0;
            end else begin
                d = (p - s + 3) % 3;
                m_num++;
                if (d == 0) begin
                    e_manche = 3; m_lw = 0;
                end else if (d == 1) begin
                    e_manche = 1; m_adv++; m_lw = 1; m_lm = p;
                end else begin
                    e_manche = 2; m_adv--; m_lw = 2; m_lm = s;
                end
                a = (m_adv < 0) ? -m_adv : m_adv;
                if (m_num == m_max || (m_num >= int'(MIN_MANCHE) && a >= int'(WIN_MARGIN))) begin
                    e_partita = (m_adv > 0) ? 1 : ((m_adv < 0) ? 2 : 3);
                    m_state = 2;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".manche"},  manche,     e_manche);
        check({tag, ".partita"}, partita,    e_partita);
        check({tag, ".vant"},    vantaggio,  m_adv);
        check({tag, ".num"},     num_manche, m_num);
        check({tag, ".busy"},    busy,       (m_state == 1) ? 1 : 0);
    endtask

    task automatic step(input int p, input int s, input bit ini, input string tag);
        @(negedge clk);
        primo   = 2'(p);
        secondo = 2'(s);
        inizia  = ini;
        @(posedge clk);
        model_step(p, s, ini);
        #1;
        check_model(tag);
    endtask

    initial begin
        int t1p[7];
        int t1s[7];
        int t1m[7];
        int t2v[5];
        t1p = '{1, 3, 1, 3, 3, 1, 3};
        t1s = '{2, 2, 3, 3, 2, 2, 3};
        t1m = '{2, 0, 1, 3, 1, 2, 3};
        t2v = '{1, 2, 1, 0, -1};

        rst = 1'b1; primo = 2'b00; secondo = 2'b00; inizia = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", {manche, partita, busy}, 0);
        check("reset.vant", vantaggio, 0);
        check("reset.num", num_manche, 0);
        @(negedge clk);
        rst = 1'b0;

        step(3, 2, 0, "idle_moves");

        // Match 1: limit 6
        step(0, 2, 1, "t1.start");
        check("t1.busy_rise", busy, 1);
        for (int i = 0; i < 7; i++) begin
            step(t1p[i], t1s[i], 0, "t1");
`ifdef MORRA_BLOCK_RULE_EN
            check("t1.manche_const", manche, t1m[i]);
`endif
        end
`ifdef MORRA_BLOCK_RULE_EN
        check("t1.num_end", num_manche, 6);
        check("t1.partita_end", partita, 3);
        check("t1.busy_fall", busy, 0);
`endif

        // Match 2: limit 5, secondo wins on the last round
        step(0, 1, 1, "t2.start");
        step(1, 3, 0, "t2"); check("t2.van0", vantaggio, t2v[0]);
        step(2, 1, 0, "t2"); check("t2.van1", vantaggio, t2v[1]);
        step(1, 2, 0, "t2"); check("t2.van2", vantaggio, t2v[2]);
        step(2, 3, 0, "t2"); check("t2.van3", vantaggio, t2v[3]);
        check("t2.partita_open", partita, 0);
        step(3, 1, 0, "t2"); check("t2.van4", vantaggio, t2v[4]);
        check("t2.partita_end", partita, 2);
        check("t2.manche_end", manche, 2);
        check("t2.busy_end", busy, 0);

        // Match 3: limit 9, margin reached below the minimum-round threshold
        step(1, 1, 1, "t3.start");
        step(1, 3, 0, "t3");
        step(2, 1, 0, "t3");
        check("t3.van_early", vantaggio, 2);
        check("t3.partita_early", partita, 0);
        check("t3.busy_early", busy, 1);
        step(1, 3, 0, "t3");
        step(1, 2, 0, "t4.blocked");
        step(0, 3, 0, "t4.none");
        step(1, 3, 0, "t4.blocked2");
`ifdef MORRA_BLOCK_RULE_EN
        check("t4.num_hold", num_manche, 3);
        check("t4.manche_inv", manche, 0);
`endif

        // Asynchronous reset in the middle of a match
        step(1, 1, 1, "t5.start");
        step(1, 3, 0, "t5");
        step(2, 1, 0, "t5");
        step(3, 3, 0, "t5");
        check("t5.num_before_rst", num_manche, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("t5.rst_outs", {manche, partita, busy}, 0);
        check("t5.rst_vant", vantaggio, 0);
        check("t5.rst_num", num_manche, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 2, 0, "t5.ignored");
        check("t5.ignored_busy", busy, 0);

        // Largest limit: 19 ties end the match
        step(3, 3, 1, "t5.max19");
        for (int i = 0; i < 19; i++) begin
            step(2, 2, 0, "t5.tie");
            if (i == 17) check("t5.partita_18", partita, 0);
        end
        check("t5.num_19", num_manche, 19);
        check("t5.partita_19", partita, 3);

        // DONE holds; inizia with moves starts without scoring
        step(1, 3, 0, "t6.done_moves");
        check("t6.manche_done", manche, 0);
        check("t6.partita_held", partita, 3);
        step(1, 3, 1, "t6.restart");
        check("t6.restart_num", num_manche, 0);
        check("t6.restart_manche", manche, 0);
        check("t6.restart_partita", partita, 0);

        // Random play
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/morra_cinese_param.md
# morra_cinese_param

Parametrised rock-paper-scissors (morra cinese) match engine, the successor to the fixed-size game FSMD. Each clock it samples two players' moves and scores one round (manche). It enforces the repeat-win rule and ends the match on a round limit or an early-win margin. Round limit base, early-win margin and minimum-round threshold are parameters; it also exports the running advantage, the round count and a busy flag for the surrounding test/display logic.

## Interface
- `CNT_W`, 5: width of the round counter and of the loaded limit; must satisfy 2^CNT_W > 15 + BASE_MANCHE.
- `BASE_MANCHE`, 4: offset added to the 4-bit limit code loaded at start.
- `MIN_MANCHE`, 4: valid rounds required before an early win is allowed.
- `WIN_MARGIN`, 2: absolute advantage that ends the match early; 1 ≤ WIN_MARGIN ≤ 2^CNT_W−1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `primo` in 2: player 1 move: 00 none, 01 sasso, 10 carta, 11 forbice.
- `secondo` in 2: player 2 move, same encoding.
- `inizia` in 1: start new match; {primo,secondo} carries the limit code.
- `manche` out 2: last round result: 00 invalid/none, 01 primo, 10 secondo, 11 tie.
- `partita` out 2: match result: 00 in progress/none, 01 primo, 10 secondo, 11 tie.
- `vantaggio` out CNT_W+1: signed running advantage (primo wins − secondo wins).
- `num_manche` out CNT_W: valid rounds played in the current match.
- `busy` out 1: high while a match is in progress.

## Operation
- States:
  - IDLE: after reset, no match loaded.
  - PLAY: match running.
  - DONE: match finished, result held.
- `inizia`=1 in any state:
  - max ← {primo,secondo} + BASE_MANCHE, range BASE_MANCHE..15+BASE_MANCHE.
  - Clear num_manche, vantaggio and the blocked move; manche←00, partita←00; go to PLAY.
- PLAY, `inizia`=0: the round is invalid if primo==00, or secondo==00, or the previous round's winner plays its previous winning move.
  - Invalid round: manche←00; counters and blocked move unchanged.
- Valid round: num_manche+1.
  - Winner by sasso>forbice, forbice>carta, carta>sasso; vantaggio ±1.
  - The winner's move becomes the blocked move for that player; a tie clears the blocked move.
- End condition, checked on the updated values: num_manche==max, or (num_manche ≥ MIN_MANCHE and |vantaggio| ≥ WIN_MARGIN).
  - On end: partita ← 01 if vantaggio>0, 10 if <0, 11 if 0; go to DONE.
- IDLE/DONE, `inizia`=0: moves ignored; manche←00; partita, vantaggio and num_manche hold.
- Arithmetic:
  - vantaggio is two's complement; |vantaggio| ≤ num_manche ≤ max, so it never overflows.
  - Limit addition is done at CNT_W bits.

## Timing
- All outputs registered. A round sampled on edge k is visible after edge k; latency is 1 cycle.
- The ending round shows its manche result and the final partita in the same cycle.
- `busy` is high during PLAY; it rises the cycle after `inizia` is sampled and falls together with the partita update.
- `inizia` has priority over move evaluation in the same cycle; the start cycle itself scores no round.
- `rst` asserted at any time, including mid-match: immediately sets IDLE, all outputs to 0, and clears the blocked move and max. The next match requires `inizia`.

## Configuration
- `MORRA_BLOCK_RULE_EN` defined: repeat-win blocking is enforced as above.
- Not defined:
  - Only a 00 move makes a round invalid.
  - No blocked-move register is synthesised; all other behaviour is identical.

## Test plan
- Default params, block rule on: inizia with 00/10 (max 6), then rounds 01v10, 11v10, 01v11, 11v11, 11v10, 01v10, 11v11.
  - manche = 10, 00, 01, 11, 01, 10, 11.
  - num_manche ends at 6; partita 11 on the last round; busy falls.
- inizia with 00/01 (max 5), then 01v11, 10v01, 01v10, 10v11, 11v01 → vantaggio 1, 2, 1, 0, −1; partita 10 after round 5.
- inizia with 01/01 (max 9), then 01v11, 10v01: vantaggio 2 at num_manche 2 → partita stays 00 (below MIN_MANCHE); the match continues.
- After a primo win with 01, apply 01v10, 00v11, 01v11 → manche 00 each time, num_manche unchanged.
  - With `MORRA_BLOCK_RULE_EN` undefined, 01v10 scores manche 10.
- Assert rst mid-match (num_manche 3): all outputs 0 at once; moves ignored until inizia; inizia with 11/11 gives max 19.
- In DONE, apply moves without inizia → manche 00, partita held; then inizia together with moves → the start wins and no round is scored that cycle.
